// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data memory with memory-mapped peripherals.
// Holds the peripheral window layout, the default window base, the TSTAT
// flag bit index and a small helper that names the register at a word offset.
package data_mem_mmio_pkg;

    // Peripheral window placement and size (bytes).
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_1000;
    localparam int unsigned MMIO_WINDOW_BYTES = 16;

    // Byte offsets of the peripheral registers inside the window.
    localparam logic [3:0] OFF_LED    = 4'h0;
    localparam logic [3:0] OFF_TCOUNT = 4'h4;
    localparam logic [3:0] OFF_TCMP   = 4'h8;
    localparam logic [3:0] OFF_TSTAT  = 4'hC;

    // Bit of TSTAT that carries the sticky match flag.
    localparam int unsigned TSTAT_IRQ_BIT = 0;

    // Compare register reset value: far from the reset count.
    localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REG_LED,
        REG_TCOUNT,
        REG_TCMP,
        REG_TSTAT
    } mmio_reg_e;

    // Map a word offset (byte offset [3:2]) to the register it selects.
    function automatic mmio_reg_e mmio_reg_decode(input logic [1:0] word_off);
        mmio_reg_e reg_sel;
        reg_sel = REG_LED;
        if (word_off == OFF_LED[3:2]) begin
            reg_sel = REG_LED;
        end else if (word_off == OFF_TCOUNT[3:2]) begin
            reg_sel = REG_TCOUNT;
        end else if (word_off == OFF_TCMP[3:2]) begin
            reg_sel = REG_TCMP;
        end else if (word_off == OFF_TSTAT[3:2]) begin
            reg_sel = REG_TSTAT;
        end
        return reg_sel;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running 32-bit timer with compare register and sticky match flag.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   i_count_we    - load TCOUNT from i_wdata (replaces this cycle's increment)
//   i_cmp_we      - load TCMP from i_wdata
//   i_stat_we     - TSTAT write; i_wdata[TSTAT_IRQ_BIT]=1 clears the flag
//   i_wdata       - store data
//   o_count       - current TCOUNT
//   o_cmp         - current TCMP
//   o_flag        - sticky match flag
module mmio_timer
    import data_mem_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_count_we,
    input  logic        i_cmp_we,
    input  logic        i_stat_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_cmp,
    output logic        o_flag
);

    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_flag;

    logic        w_match;
    logic        w_clear;
    logic        w_flag_next;

    // Match uses pre-edge values; a coincident clear loses to the set.
    assign w_match     = (r_count == r_cmp);
    assign w_clear     = i_stat_we & i_wdata[TSTAT_IRQ_BIT];
    assign w_flag_next = w_match | (r_flag & ~w_clear);

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_cmp   <= TCMP_RESET;
            r_flag  <= 1'b0;
        end else begin
            r_count <= i_count_we ? i_wdata : (r_count + 32'd1);
            if (i_cmp_we) begin
                r_cmp <= i_wdata;
            end
            r_flag  <= w_flag_next;
        end
    end

    assign o_count = r_count;
    assign o_cmp   = r_cmp;
    assign o_flag  = r_flag;

endmodule

// File: rtl/data_mem_mmio.sv
// Word-addressed data RAM plus a 16-byte peripheral window (LED, timer)
// for a single-cycle core. Loads are combinational, stores commit on the edge.
// Ports:
//   clk, reset - clock, synchronous active-high reset (RAM is not reset)
//   address    - byte address from the core; bits [1:0] ignored
//   writeData  - store data
//   memWrite   - store strobe for the current cycle
//   readData   - load data, combinational from address
//   leds       - LED register
//   timerIrq   - sticky timer match flag
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memWrite,
    output logic [31:0] readData,
    output logic [7:0]  leds,
    output logic        timerIrq
);

    localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [31:0] MMIO_END  = MMIO_BASE + 32'(MMIO_WINDOW_BYTES);

    logic [31:0] r_ram [RAM_WORDS];
    logic [7:0]  r_leds;

    logic             w_in_ram;
    logic             w_in_mmio;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_word_off;
    mmio_reg_e        w_reg;
    logic             w_mmio_we;
    logic             w_led_we;
    logic [31:0]      w_tcount;
    logic [31:0]      w_tcmp;
    logic             w_flag;

    // Region decode; RAM takes priority should the regions ever overlap.
    assign w_in_ram   = (address < RAM_BYTES);
    assign w_in_mmio  = !w_in_ram && (address >= MMIO_BASE) && (address < MMIO_END);
    assign w_idx      = address[IDX_W+1:2];
    assign w_word_off = 2'((address - MMIO_BASE) >> 2);
    assign w_reg      = mmio_reg_decode(w_word_off);
    assign w_mmio_we  = memWrite && w_in_mmio;
    assign w_led_we   = w_mmio_we && (w_reg == REG_LED);

    // RAM array: no reset on contents; stores are held off while in reset.
    always_ff @(posedge clk) begin
        if (memWrite && w_in_ram && !reset) begin
            r_ram[w_idx] <= writeData;
        end
    end

    // LED register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds <= '0;
        end else if (w_led_we) begin
            r_leds <= writeData[7:0];
        end
    end

    mmio_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_count_we (w_mmio_we && (w_reg == REG_TCOUNT)),
        .i_cmp_we   (w_mmio_we && (w_reg == REG_TCMP)),
        .i_stat_we  (w_mmio_we && (w_reg == REG_TSTAT)),
        .i_wdata    (writeData),
        .o_count    (w_tcount),
        .o_cmp      (w_tcmp),
        .o_flag     (w_flag)
    );

    // Zero-latency load mux; unmapped addresses read as zero.
    always_comb begin
        readData = '0;
        if (w_in_ram) begin
            readData = r_ram[w_idx];
        end else if (w_in_mmio) begin
            case (w_reg)
                REG_LED:    readData = {24'h0, r_leds};
                REG_TCOUNT: readData = w_tcount;
                REG_TCMP:   readData = w_tcmp;
                REG_TSTAT:  readData = {31'h0, w_flag};
                default:    readData = '0;
            endcase
        end
    end

    assign leds     = r_leds;
    assign timerIrq = w_flag;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed stimulus with expected
// values queued at drive time and compared at the following falling edge.
module tb_data_mem_mmio;

    localparam logic [31:0] A_LED    = 32'h0000_1000;
    localparam logic [31:0] A_TCOUNT = 32'h0000_1004;
    localparam logic [31:0] A_TCMP   = 32'h0000_1008;
    localparam logic [31:0] A_TSTAT  = 32'h0000_100C;

    localparam int SEL_RD  = 0;
    localparam int SEL_LED = 1;
    localparam int SEL_IRQ = 2;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic [31:0] readData;
    logic [7:0]  leds;
    logic        timerIrq;

    int  n_checks;
    int  n_fail;
    sb_t sb_q[$];

    data_mem_mmio #(
        .RAM_WORDS (64),
        .MMIO_BASE (32'h0000_1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .writeData (writeData),
        .memWrite  (memWrite),
        .readData  (readData),
        .leds      (leds),
        .timerIrq  (timerIrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard drain: compare every expectation queued this cycle.
    always @(negedge clk) begin
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_RD:  check(e.tag, readData, e.exp);
                SEL_LED: check(e.tag, {24'h0, leds}, e.exp);
                default: check(e.tag, {31'h0, timerIrq}, e.exp);
            endcase
        end
    end

    task automatic drive(input logic rst, input logic [31:0] addr,
                         input logic [31:0] wd, input logic we);
        @(posedge clk);
        #1;
        reset     = rst;
        address   = addr;
        writeData = wd;
        memWrite  = we;
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        drive(1'b0, addr, wd, 1'b1);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b0, addr, 32'h0, 1'b0);
        push(tag, SEL_RD, exp);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        address   = 32'h0;
        writeData = 32'h0;
        memWrite  = 1'b0;

        // Reset values.
        drive(1'b1, A_LED, 32'h0, 1'b0);
        push("rst_led_rd", SEL_RD, 32'h0);
        push("rst_leds", SEL_LED, 32'h0);
        push("rst_irq", SEL_IRQ, 32'h0);
        drive(1'b1, A_TCMP, 32'h0, 1'b0);
        push("rst_tcmp", SEL_RD, 32'hFFFF_FFFF);
        drive(1'b1, A_TCOUNT, 32'h0, 1'b0);
        push("rst_tcount", SEL_RD, 32'h0);
        drive(1'b1, A_TSTAT, 32'h0, 1'b0);
        push("rst_tstat", SEL_RD, 32'h0);

        // Counting and first match (TCMP=5).
        rd("cnt_0", A_TCOUNT, 32'd0);
        rd("cnt_1", A_TCOUNT, 32'd1);
        wr(A_TCMP, 32'd5);
        rd("tcmp_rd", A_TCMP, 32'd5);
        rd("cnt_4", A_TCOUNT, 32'd4);
        push("irq_lo_4", SEL_IRQ, 32'h0);
        rd("cnt_5", A_TCOUNT, 32'd5);
        push("irq_lo_5", SEL_IRQ, 32'h0);
        rd("tstat_set", A_TSTAT, 32'h1);
        push("irq_hi", SEL_IRQ, 32'h1);
        rd("tstat_sticky", A_TSTAT, 32'h1);

        // Clear, set-wins-over-clear, TSTAT=0 no effect.
        wr(A_TSTAT, 32'h1);
        rd("tstat_clr", A_TSTAT, 32'h0);
        wr(A_TCOUNT, 32'd20);
        wr(A_TCMP, 32'd22);
        rd("cnt_21", A_TCOUNT, 32'd21);
        wr(A_TSTAT, 32'h1);
        rd("set_wins", A_TSTAT, 32'h1);
        push("set_wins_irq", SEL_IRQ, 32'h1);
        wr(A_TSTAT, 32'h0);
        rd("tstat0_noeff", A_TSTAT, 32'h1);
        wr(A_TSTAT, 32'h1);
        rd("tstat_clr2", A_TSTAT, 32'h0);
        push("irq_clr2", SEL_IRQ, 32'h0);

        // Counter wrap.
        wr(A_TCOUNT, 32'hFFFF_FFFE);
        rd("wrap_fe", A_TCOUNT, 32'hFFFF_FFFE);
        rd("wrap_ff", A_TCOUNT, 32'hFFFF_FFFF);
        rd("wrap_00", A_TCOUNT, 32'h0);

        // RAM words, byte-offset aliasing and region edges.
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'h14, 32'h1234_5678);
        rd("ram_10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_14", 32'h14, 32'h1234_5678);
        rd("ram_13", 32'h13, 32'hDEAD_BEEF);
        wr(32'h0, 32'hCAFE_F00D);
        wr(32'hFC, 32'hA5A5_0001);
        wr(32'h100, 32'h1111_1111);
        rd("ram_top", 32'hFC, 32'hA5A5_0001);
        rd("ram_noalias", 32'h0, 32'hCAFE_F00D);
        rd("ram_end", 32'h100, 32'h0);
        rd("mmio_end", 32'h1010, 32'h0);
        rd("mmio_below", 32'hFFC, 32'h0);

        // LED register.
        wr(A_LED, 32'h1A5);
        rd("led_rd", A_LED, 32'h0000_00A5);
        push("led_out", SEL_LED, 32'hA5);
        wr(32'h1002, 32'h3C);
        rd("led_off2", A_LED, 32'h3C);
        push("led_out2", SEL_LED, 32'h3C);

        // Unmapped access changes nothing.
        rd("unmap_rd", 32'h2000, 32'h0);
        wr(32'h2000, 32'hFFFF_FFFF);
        rd("unmap_led", A_LED, 32'h3C);
        rd("unmap_ram10", 32'h10, 32'hDEAD_BEEF);
        rd("unmap_ram0", 32'h0, 32'hCAFE_F00D);

        // Raise the flag, then reset mid-run with a competing LED write.
        wr(A_TCOUNT, 32'd50);
        wr(A_TCMP, 32'd51);
        rd("cnt_51", A_TCOUNT, 32'd51);
        rd("pre_rst_flag", A_TSTAT, 32'h1);
        drive(1'b1, A_LED, 32'hFF, 1'b1);
        push("rst_pre_edge", SEL_RD, 32'h3C);
        drive(1'b1, 32'h10, 32'h0, 1'b0);
        push("rst_ram_kept", SEL_RD, 32'hDEAD_BEEF);
        push("rst2_leds", SEL_LED, 32'h0);
        push("rst2_irq", SEL_IRQ, 32'h0);
        drive(1'b1, A_TCMP, 32'h0, 1'b0);
        push("rst2_tcmp", SEL_RD, 32'hFFFF_FFFF);
        rd("rst2_cnt0", A_TCOUNT, 32'd0);
        rd("rst2_cnt1", A_TCOUNT, 32'd1);
        rd("rst2_led", A_LED, 32'h0);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 Parameter RAM_WORDS, default 64: RAM depth in 32-bit words; power of two.
REQ-002 Parameter MMIO_BASE, default 32'h0000_1000: base address of the 16-byte peripheral window.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port address, input, 32: byte address; the core's aluResult.
REQ-006 Port writeData, input, 32: store data from the core.
REQ-007 Port memWrite, input, 1: store strobe for the current cycle.
REQ-008 Port readData, output, 32: load data returned to the core.
REQ-009 Port leds, output, 8: LED register contents.
REQ-010 Port timerIrq, output, 1: sticky timer-match flag.

Function
REQ-011 Block SHALL use word access only; address[1:0] ignored on reads and writes.
REQ-012 RAM region SHALL be address < RAM_WORDS*4, indexed by address[log2(RAM_WORDS)+1:2].
REQ-013 MMIO region SHALL be MMIO_BASE <= address < MMIO_BASE+16; offsets 0x0 LED, 0x4 TCOUNT, 0x8 TCMP, 0xC TSTAT.
REQ-014 readData SHALL be combinational from address in the same cycle (zero-latency load for the single-cycle core).
REQ-015 A RAM write SHALL commit at the rising edge when memWrite=1; a read of that word is visible from the next cycle.
REQ-016 A read of an unmapped address SHALL return 32'h0; a write to one SHALL change no state.
REQ-017 LED write SHALL load writeData[7:0]; LED read SHALL return {24'h0, leds}.
REQ-018 TCOUNT SHALL increment by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
REQ-019 TCOUNT write SHALL load writeData and suppress that cycle's increment.
REQ-020 TCMP SHALL be read/write; a write takes effect on the next edge.
REQ-021 The match flag SHALL set on the edge where the pre-edge TCOUNT equals the pre-edge TCMP.
REQ-022 A TSTAT write with writeData[0]=1 SHALL clear the flag; writeData[0]=0 SHALL have no effect.
REQ-023 When set and clear coincide in one cycle, set SHALL win.
REQ-024 TSTAT read SHALL return {31'h0, flag}; timerIrq SHALL equal the flag.

Reset
REQ-025 While reset=1 at an edge: leds=0, TCOUNT=0, TCMP=32'hFFFF_FFFF, flag=0; reset overrides writes.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 readData SHALL follow the REQ-014 decode during reset and reflect the reset values after it.
REQ-028 Reset asserted mid-count SHALL restart TCOUNT at 0 on the first cycle after deassertion.

Structure
REQ-029 A shared package SHALL hold the MMIO offset constants, the default MMIO_BASE and the TSTAT bit index.
REQ-030 The counter, compare register and match flag SHALL live in sub-module mmio_timer.
REQ-031 The RAM array and address decode SHALL stay in data_mem_mmio.

Verification
REQ-032 Write 0xDEADBEEF to 0x10, then write 0x12345678 to 0x14 -> reading 0x10 returns 0xDEADBEEF and 0x14 returns 0x12345678; a read at 0x13 returns 0xDEADBEEF.
REQ-033 Write 0x1A5 to 0x1000 -> leds=0xA5, and a read of 0x1000 returns 0x000000A5.
REQ-034 Write TCMP=5 after reset, then wait -> timerIrq rises on the edge after TCOUNT reads 5, and stays high.
REQ-035 Write TSTAT=1 in the same cycle a match occurs -> flag stays 1; a later TSTAT=1 clears it, and TSTAT=0 does not.
REQ-036 Write TCOUNT=0xFFFF_FFFE -> reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0 on successive cycles.
REQ-037 Read 0x2000, write 0x2000, then assert reset mid-run -> the read returns 0, the write changes nothing, and leds, TCOUNT, TCMP and irq return to their reset values.
